// File: rtl/irq_enc8to3.sv
`default_nettype none
// ============================================================================
//  Module   : irq_enc8to3
//  Purpose  : Sequential 8-to-3 priority encoder. Rising edges on eight
//             request lines are captured into a pending register; each
//             captured line is reported exactly once as a 3-bit code through
//             a valid/ack handshake. Lowest index has highest priority.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk      in   system clock, all state changes on the rising edge
//    rst_n    in   synchronous active-low reset
//    req      in   [0:7] level request lines, req[0] maps to code 0
//    en       in   capture enable (gates new captures only)
//    ack      in   consumer accepts the current code
//    code     out  [2:0] registered index of the reported line
//    valid    out  code is valid, held stable until acknowledged
//    pend_cnt out  [3:0] number of lines captured but not yet reported
//    ovf      out  sticky: an edge arrived on a line that was still pending
// ============================================================================
module irq_enc8to3 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [0:7] req,
    input  logic       en,
    input  logic       ack,
    output logic [2:0] code,
    output logic       valid,
    output logic [3:0] pend_cnt,
    output logic       ovf
);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [0:7] r_req_d;
    logic [0:7] r_pend;
    logic [2:0] r_code;
    logic       r_valid;
    logic       r_ovf;

    // ------------------------------------------------------------------------
    // Combinational
    // ------------------------------------------------------------------------
    logic [0:7] w_rise;
    logic [0:7] w_cap;
    logic [0:7] w_clr;
    logic [0:7] w_pend_nxt;
    logic [0:7] w_ovf_hit;
    logic       w_any;
    logic       w_load;
    logic       w_drop;
    logic [2:0] w_idx;
    logic [3:0] w_cnt;

    assign w_any  = |r_pend;
    // Output register is free when empty or being acknowledged this edge.
    assign w_load = (~r_valid | ack) & w_any;
    // Acknowledged with nothing left to report: release the output.
    assign w_drop = r_valid & ack & ~w_any;

    // Lowest set index wins: scan downward so the last hit is the lowest.
    always_comb begin
        w_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (r_pend[i]) begin
                w_idx = 3'(i);
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_bit
            assign w_rise[gi]     = req[gi] & ~r_req_d[gi];
            assign w_cap[gi]      = en & w_rise[gi];
            assign w_clr[gi]      = w_load & (w_idx == 3'(gi));
            // A capture on the same edge that reports the line re-arms it,
            // so the set term is ORed after the clear.
            assign w_pend_nxt[gi] = w_cap[gi] | (r_pend[gi] & ~w_clr[gi]);
            // Only a capture that is not absorbed by a same-edge report
            // collapses two events into one.
            assign w_ovf_hit[gi]  = w_cap[gi] & r_pend[gi] & ~w_clr[gi];
        end
    endgenerate

    always_comb begin
        w_cnt = 4'd0;
        for (int i = 0; i < 8; i++) begin
            w_cnt = w_cnt + {3'd0, r_pend[i]};
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_req_d <= '0;
            r_pend  <= '0;
            r_code  <= 3'd0;
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            // Edge history tracks req even while captures are disabled, so
            // a line held high across enable does not produce a late edge.
            r_req_d <= req;
            r_pend  <= w_pend_nxt;
            if (w_load) begin
                r_code  <= w_idx;
                r_valid <= 1'b1;
            end else if (w_drop) begin
                r_valid <= 1'b0;
            end
            if (|w_ovf_hit) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign code     = r_code;
    assign valid    = r_valid;
    assign ovf      = r_ovf;
    assign pend_cnt = w_cnt;

endmodule
`default_nettype wire

// File: tb/tb_irq_enc8to3.sv
`default_nettype none
// ============================================================================
//  Module   : tb_irq_enc8to3
//  Purpose  : Directed self-checking bench for irq_enc8to3.
//  Revision : 1.0  initial release
// ============================================================================
module tb_irq_enc8to3;

    logic       clk;
    logic       rst_n;
    logic [0:7] req;
    logic       en;
    logic       ack;
    logic [2:0] code;
    logic       valid;
    logic [3:0] pend_cnt;
    logic       ovf;

    int checks = 0;
    int errors = 0;

    irq_enc8to3 dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .en       (en),
        .ack      (ack),
        .code     (code),
        .valid    (valid),
        .pend_cnt (pend_cnt),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; inputs are driven and outputs sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 8'hFF;
        en    = 1'b1;
        ack   = 1'b0;

        // ---------------- reset ----------------
        tick(); tick();
        chk("rst_code",  code, 0);
        chk("rst_valid", valid, 0);
        chk("rst_cnt",   pend_cnt, 0);
        chk("rst_ovf",   ovf, 0);
        rst_n = 1'b1;
        tick();
        chk("rel_cnt8",   pend_cnt, 8);
        chk("rel_valid0", valid, 0);
        tick();
        chk("rel_valid1", valid, 1);
        chk("rel_code0",  code, 0);
        chk("rel_cnt7",   pend_cnt, 7);
        // drain remaining seven back to back
        ack = 1'b1;
        for (int i = 1; i < 8; i++) begin
            tick();
            chk("drain_code",  code, i);
            chk("drain_valid", valid, 1);
            chk("drain_cnt",   pend_cnt, 7 - i);
        end
        tick();
        chk("drain_end_valid", valid, 0);
        chk("drain_end_code",  code, 7);
        ack = 1'b0;
        req = '0;
        tick();

        // ---------------- single line ----------------
        req[5] = 1'b1;
        tick();
        chk("s_cnt1",   pend_cnt, 1);
        chk("s_valid0", valid, 0);
        tick();
        chk("s_valid1", valid, 1);
        chk("s_code5",  code, 5);
        chk("s_cnt0",   pend_cnt, 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("s_hold_code",  code, 5);
            chk("s_hold_valid", valid, 1);
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("s_ack_valid", valid, 0);
        chk("s_ack_code",  code, 5);
        req = '0;
        tick();

        // ---------------- priority burst ----------------
        ack = 1'b1;
        req[1] = 1'b1; req[3] = 1'b1; req[6] = 1'b1;
        tick();
        chk("b_cnt3", pend_cnt, 3);
        tick();
        chk("b_code1", code, 1); chk("b_v1", valid, 1); chk("b_cnt2", pend_cnt, 2);
        tick();
        chk("b_code3", code, 3); chk("b_v3", valid, 1); chk("b_cnt1", pend_cnt, 1);
        tick();
        chk("b_code6", code, 6); chk("b_v6", valid, 1); chk("b_cnt0", pend_cnt, 0);
        tick();
        chk("b_end_valid", valid, 0);
        ack = 1'b0;
        req = '0;
        tick();

        // ---------------- overflow ----------------
        req[0] = 1'b1;
        tick(); tick();
        chk("o_busy_code", code, 0);
        chk("o_busy_v",    valid, 1);
        req[2] = 1'b1;
        tick();
        chk("o_cnt1", pend_cnt, 1);
        chk("o_ovf0", ovf, 0);
        req[2] = 1'b0;
        tick();
        req[2] = 1'b1;
        tick();
        chk("o_ovf1",   ovf, 1);
        chk("o_cnt1b",  pend_cnt, 1);
        chk("o_code0",  code, 0);
        ack = 1'b1;
        tick();
        chk("o_code2", code, 2);
        chk("o_v2",    valid, 1);
        chk("o_cnt0",  pend_cnt, 0);
        tick();
        chk("o_once",  valid, 0);
        chk("o_ovf_sticky", ovf, 1);
        ack = 1'b0;
        req = '0;
        tick();

        // reset clears the sticky flag
        rst_n = 1'b0;
        tick();
        chk("r2_ovf",   ovf, 0);
        chk("r2_valid", valid, 0);
        rst_n = 1'b1;

        // ---------------- disable ----------------
        en = 1'b0;
        req[4] = 1'b1;
        tick(); tick();
        chk("d_cnt0",   pend_cnt, 0);
        chk("d_valid0", valid, 0);
        en = 1'b1;
        tick(); tick();
        chk("d_en_cnt0",   pend_cnt, 0);
        chk("d_en_valid0", valid, 0);
        req[4] = 1'b0;
        tick();
        req[4] = 1'b1;
        tick();
        chk("d_cnt1", pend_cnt, 1);
        tick();
        chk("d_code4", code, 4);
        chk("d_v4",    valid, 1);
        ack = 1'b1;
        tick();
        chk("d_end_valid", valid, 0);
        ack = 1'b0;
        req = '0;
        tick();

        // ---------------- set/clear collision ----------------
        req[0] = 1'b1; req[7] = 1'b1;
        tick();
        chk("c_cnt2", pend_cnt, 2);
        tick();
        chk("c_code0", code, 0);
        chk("c_cnt1",  pend_cnt, 1);
        req[7] = 1'b0;
        tick();
        req[7] = 1'b1;
        ack = 1'b1;
        tick();
        chk("c_code7a", code, 7);
        chk("c_v7a",    valid, 1);
        chk("c_cnt_keep", pend_cnt, 1);
        chk("c_ovf0",   ovf, 0);
        tick();
        chk("c_code7b", code, 7);
        chk("c_v7b",    valid, 1);
        chk("c_cnt0",   pend_cnt, 0);
        tick();
        chk("c_end_valid", valid, 0);
        chk("c_end_ovf",   ovf, 0);
        ack = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
